// File: rtl/seven_seg_scheduler.sv
// seven_seg_scheduler: shares one 4-digit seven-segment controller between
// up to four 16-bit sources. Sources rotate round-robin on a dwell timer, and
// an update event from a source pre-empts the rotation for a hold period.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_SCAN   | round-robin rotation, dwell timer advances sel
// ST_HOLD   | event-selected source shown for HOLD_CYCLES
// ST_FREEZE | selection and timers parked while freeze is high
module seven_seg_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [16*NUM_SRC-1:0]  src_data,
  input  logic [NUM_SRC-1:0]     src_event,
  input  logic                   freeze,
  output logic [15:0]            dataIn,
  output logic [3:0]             digitDisplay,
  output logic [3:0]             digitPoint,
  output logic [1:0]             sel
);

  localparam int DWELL_W = $clog2(DWELL_CYCLES);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [1:0]         SEL_LAST   = 2'(NUM_SRC - 1);
  localparam logic [3:0]         DISP_RST   = BLANK_LZ ? 4'b0001 : 4'b1111;

  typedef enum logic [1:0] {ST_SCAN, ST_HOLD, ST_FREEZE} state_e;

  state_e               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [NUM_SRC-1:0]   pending_q, pending_d, clr_mask;
  logic [1:0]           low_idx;
  logic                 take_pend;
  logic [15:0]          data_d;
  logic [3:0]           disp_d;

  // Lowest-index pending source; loop runs high to low so the lowest wins.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = 2'(i);
    end
  end

  // Selection FSM next-state: freeze overrides, pending beats dwell advance.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    dwell_d   = dwell_q;
    hold_d    = hold_q;
    take_pend = 1'b0;
    if (freeze) begin
      state_d = ST_FREEZE;
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (pending_q != '0) begin
            state_d   = ST_HOLD;
            sel_d     = low_idx;
            hold_d    = '0;
            take_pend = 1'b1;
          end else if (dwell_q == DWELL_LAST) begin
            sel_d   = (sel_q == SEL_LAST) ? 2'd0 : sel_q + 2'd1;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end
        ST_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            if (pending_q != '0) begin
              sel_d     = low_idx;
              hold_d    = '0;
              take_pend = 1'b1;
            end else begin
              state_d = ST_SCAN;
              dwell_d = '0;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        default: begin
          state_d = ST_SCAN;
          dwell_d = '0;
        end
      endcase
    end
  end

  // Pending bookkeeping: a new event on the same cycle beats the clear.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_mask[i] = take_pend && (low_idx == 2'(i));
    end
    pending_d = (pending_q & ~clr_mask) | src_event;
  end

  // Display value for the next selection and its leading-zero digit enables.
  always_comb begin
    data_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_d == 2'(i)) data_d = src_data[16*i +: 16];
    end
    if (BLANK_LZ) begin
      disp_d[3] = |data_d[15:12];
      disp_d[2] = disp_d[3] | (|data_d[11:8]);
      disp_d[1] = disp_d[2] | (|data_d[7:4]);
      disp_d[0] = 1'b1;
    end else begin
      disp_d = 4'b1111;
    end
  end

  // State, timers, pending and registered display outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_SCAN;
      sel_q        <= '0;
      dwell_q      <= '0;
      hold_q       <= '0;
      pending_q    <= '0;
      dataIn       <= '0;
      digitDisplay <= DISP_RST;
      digitPoint   <= 4'b0001;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      dwell_q      <= dwell_d;
      hold_q       <= hold_d;
      pending_q    <= pending_d;
      dataIn       <= data_d;
      digitDisplay <= disp_d;
      digitPoint   <= 4'b0001 << sel_d;
    end
  end

  assign sel = sel_q;

endmodule

// File: tb/tb_seven_seg_scheduler.sv
// Directed bench for seven_seg_scheduler with an expected-output scoreboard.
module tb_seven_seg_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] src_data;
  logic [3:0]  src_event;
  logic        freeze;
  logic [15:0] dataIn;
  logic [3:0]  digitDisplay;
  logic [3:0]  digitPoint;
  logic [1:0]  sel;

  logic [15:0] src [4];
  assign src_data = {src[3], src[2], src[1], src[0]};

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] data;
    logic [3:0]  disp;
    logic [3:0]  pt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  seven_seg_scheduler #(
    .NUM_SRC(4), .DWELL_CYCLES(8), .HOLD_CYCLES(4), .BLANK_LZ(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .src_data(src_data), .src_event(src_event),
    .freeze(freeze), .dataIn(dataIn), .digitDisplay(digitDisplay),
    .digitPoint(digitPoint), .sel(sel)
  );

  always #5 clk = ~clk;

  // Enables up to the most significant nonzero nibble; digit 0 always lit.
  function automatic logic [3:0] lz_mask(input logic [15:0] v);
    int top;
    logic [3:0] m;
    top = 0;
    for (int k = 0; k < 4; k++) begin
      if (((v >> (4 * k)) & 16'h000F) != 16'h0000) top = k;
    end
    m = 4'b0000;
    for (int k = 0; k <= top; k++) m[k] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic push_exp(input int s, input logic [15:0] d);
    exp_t e;
    e.sel  = 2'(s);
    e.data = d;
    e.disp = lz_mask(d);
    e.pt   = 4'b0001 << s;
    sb_q.push_back(e);
  endtask

  // Advance one clock, then compare the DUT against the oldest expectation.
  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty @cycle %0d: observed no entry required one", cyc);
    end else begin
      e = sb_q.pop_front();
      chk("sel", 16'(sel), 16'(e.sel));
      chk("dataIn", dataIn, e.data);
      chk("digitDisplay", 16'(digitDisplay), 16'(e.disp));
      chk("digitPoint", 16'(digitPoint), 16'(e.pt));
    end
  endtask

  task automatic exp_run(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      push_exp(s, src[s]);
      tick_check();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    freeze    = 1'b0;
    src_event = 4'b0000;
    src[0] = 16'h0001; src[1] = 16'h0022; src[2] = 16'h0333; src[3] = 16'h4444;

    // reset values
    push_exp(0, 16'h0000);
    tick_check();
    reset = 1'b1;

    // plain round-robin, 8 cycles per source
    exp_run(0, 7);
    exp_run(1, 8);
    exp_run(2, 8);
    exp_run(3, 8);
    exp_run(0, 1);

    // single event on source 2: held 4 cycles, then full dwell on 2
    src_event = 4'b0100;
    exp_run(0, 1);
    src_event = 4'b0000;
    exp_run(2, 12);
    exp_run(3, 1);

    // two simultaneous events: hold 1 then hold 3, then scan from 3
    src_event = 4'b1010;
    exp_run(3, 1);
    src_event = 4'b0000;
    exp_run(1, 4);
    exp_run(3, 12);
    exp_run(0, 1);

    // freeze for 20 cycles with an event on source 0 meanwhile
    exp_run(0, 7);
    exp_run(1, 3);
    freeze = 1'b1;
    exp_run(1, 5);
    src_event = 4'b0001;
    exp_run(1, 1);
    src_event = 4'b0000;
    exp_run(1, 14);
    freeze = 1'b0;
    exp_run(1, 1);
    exp_run(0, 1);

    // reset during HOLD with source 3 pending: pending is discarded
    src_event = 4'b1000;
    exp_run(0, 1);
    src_event = 4'b0000;
    reset = 1'b0;
    push_exp(0, 16'h0000);
    tick_check();
    reset = 1'b1;
    exp_run(0, 7);
    exp_run(1, 1);

    // mid-dwell data changes and leading-zero blanking
    src[1] = 16'h0009;
    exp_run(1, 2);
    src[1] = 16'h0A00;
    exp_run(1, 2);
    src[1] = 16'h1000;
    exp_run(1, 1);
    src[1] = 16'h0005;
    exp_run(1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
